// File: rtl/stream_scoreboard.sv
// rtl/stream_scoreboard.sv - in-order stream checker with expected-data FIFO and drain FSM.
// Optional byte-masked compare via STREAM_SCOREBOARD_BYTE_MASK_EN.
module stream_scoreboard #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1024,
  parameter int PROG_FULL = 768,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DATA_W-1:0] exp_in,
  input  logic              exp_in_en,
  input  logic              stream_end,
  input  logic [DATA_W-1:0] dut_out,
  input  logic              dut_out_en,
`ifdef STREAM_SCOREBOARD_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] cmp_mask,
`endif
  output logic              prog_full,
  output logic [CNT_W-1:0]  in_cnt,
  output logic [CNT_W-1:0]  out_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err,
  output logic              overflow,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic              done,
  output logic              pass
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE, FAIL} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr, occ, occ_next;
  logic [CNT_W-1:0]    idle, idle_n;
  logic [DATA_W-1:0]   head, cmp_bits;
  logic                empty, full, push, pop, drop, underflow, mismatch, err_ev;
  logic                err_n, ovf_n, done_n, pass_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cmp_bits = '1;
`ifdef STREAM_SCOREBOARD_BYTE_MASK_EN
    for (int i = 0; i < DATA_W/8; i++) cmp_bits[i*8 +: 8] = {8{~cmp_mask[i]}};
`endif
    occ       = wr_ptr - rd_ptr;
    empty     = (occ == '0);
    full      = (occ == (AW+1)'(DEPTH));
    head      = mem[rd_ptr[AW-1:0]];
    pop       = dut_out_en & ~empty;
    // Only RUN accepts new expected beats; anything later is extra feeder output.
    push      = exp_in_en & (state == RUN) & (~full | pop);
    drop      = exp_in_en & ~push;
    underflow = dut_out_en & empty;
    mismatch  = pop & (((dut_out ^ head) & cmp_bits) != '0);
    err_ev    = mismatch | underflow;
    occ_next  = occ + (AW+1)'(push) - (AW+1)'(pop);

    state_n = state;
    idle_n  = idle;
    case (state)
      RUN: if (stream_end) begin
        state_n = DRAIN;
        idle_n  = '0;
      end
      DRAIN: begin
        if (empty && !push) state_n = DONE;
        else if (dut_out_en) idle_n = '0;
        else begin
          idle_n = idle + CNT_W'(1);
          if (idle == CNT_W'(TIMEOUT - 1)) state_n = FAIL;
        end
      end
      default: ;
    endcase

    err_n  = err | err_ev | (state_n == FAIL);
    ovf_n  = overflow | drop;
    done_n = (state_n == DONE) || (state_n == FAIL);
    pass_n = done_n & ~err_n & ~ovf_n;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= exp_in;
  end

  always_ff @(posedge clk) begin
    if (!srst) begin
      state         <= RUN;
      idle          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      prog_full     <= 1'b0;
      in_cnt        <= '0;
      out_cnt       <= '0;
      stall_cnt     <= '0;
      err_cnt       <= '0;
      err           <= 1'b0;
      overflow      <= 1'b0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state     <= state_n;
      idle      <= idle_n;
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        in_cnt <= sat_inc(in_cnt);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (dut_out_en) out_cnt <= sat_inc(out_cnt);
      if (prog_full) stall_cnt <= sat_inc(stall_cnt);
      if (err_ev) err_cnt <= sat_inc(err_cnt);
      // Index is the pre-increment out_cnt, i.e. the 0-based failing beat.
      if (err_ev && !err) begin
        first_err_idx <= out_cnt;
        first_err_exp <= underflow ? '0 : head;
        first_err_act <= dut_out;
      end
      prog_full <= (occ_next >= (AW+1)'(PROG_FULL));
      err       <= err_n;
      overflow  <= ovf_n;
      done      <= done_n;
      pass      <= pass_n;
    end
  end
endmodule

// File: tb/tb_stream_scoreboard.sv
// tb/tb_stream_scoreboard.sv - directed self-checking bench for stream_scoreboard.
module tb_stream_scoreboard;
  logic        clk = 1'b0;
  logic        srst, exp_in_en, stream_end, dut_out_en;
  logic [7:0]  exp_in, dut_out;
`ifdef STREAM_SCOREBOARD_BYTE_MASK_EN
  logic [0:0]  cmp_mask = '0;
`endif
  logic        prog_full, err, overflow, done, pass;
  logic [31:0] in_cnt, out_cnt, stall_cnt, err_cnt, first_err_idx;
  logic [7:0]  first_err_exp, first_err_act;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  stream_scoreboard #(.DATA_W(8), .DEPTH(16), .PROG_FULL(12), .CNT_W(32), .TIMEOUT(100)) dut (
    .clk(clk), .srst(srst), .exp_in(exp_in), .exp_in_en(exp_in_en), .stream_end(stream_end),
    .dut_out(dut_out), .dut_out_en(dut_out_en),
`ifdef STREAM_SCOREBOARD_BYTE_MASK_EN
    .cmp_mask(cmp_mask),
`endif
    .prog_full(prog_full), .in_cnt(in_cnt), .out_cnt(out_cnt), .stall_cnt(stall_cnt),
    .err_cnt(err_cnt), .err(err), .overflow(overflow), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_act(first_err_act), .done(done), .pass(pass)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    srst = 1'b0; exp_in_en = 1'b0; dut_out_en = 1'b0; stream_end = 1'b0;
    exp_in = '0; dut_out = '0;
    tick;
    srst = 1'b1;
  endtask

  // Feeder sends 0..n-1; DUT echoes each beat `delay` cycles later, flipping bit 7 on bad beats.
  task automatic run_stream(input int n, input int delay, input int bad1, input int bad2);
    int d;
    for (int c = 0; c < n + delay; c++) begin
      exp_in_en  = (c < n);
      exp_in     = c[7:0];
      d          = c - delay;
      dut_out_en = (d >= 0);
      dut_out    = d[7:0];
      if (d == bad1 || d == bad2) dut_out = dut_out ^ 8'h80;
      tick;
    end
    exp_in_en = 1'b0; dut_out_en = 1'b0; stream_end = 1'b1;
    for (int i = 0; i < 20 && !done; i++) tick;
    check("stream_done", done, 1);
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      exp_in_en = 1'b1; exp_in = base + i[7:0];
      tick;
    end
    exp_in_en = 1'b0;
  endtask

  initial begin
    do_reset;
    check("rst_in_cnt", in_cnt, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_prog_full", prog_full, 0);

    run_stream(256, 5, -1, -1);
    check("t1_pass", pass, 1);
    check("t1_in_cnt", in_cnt, 256);
    check("t1_out_cnt", out_cnt, 256);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_stall", stall_cnt, 0);
    exp_in_en = 1'b1; exp_in = 8'h11; tick; exp_in_en = 1'b0;
    check("t1_late_push_ovf", overflow, 1);
    check("t1_late_push_pass", pass, 0);
    check("t1_late_push_in_cnt", in_cnt, 256);

    do_reset;
    run_stream(256, 5, 37, 90);
    check("t2_err", err, 1);
    check("t2_err_cnt", err_cnt, 2);
    check("t2_idx", first_err_idx, 37);
    check("t2_exp", first_err_exp, 8'h25);
    check("t2_act", first_err_act, 8'hA5);
    check("t2_pass", pass, 0);

    do_reset;
    for (int i = 0; i < 12; i++) begin
      exp_in_en = 1'b1; exp_in = i[7:0];
      tick;
      if (i == 10) check("t3_pf_at_11", prog_full, 0);
    end
    exp_in_en = 1'b0;
    check("t3_pf_at_12", prog_full, 1);
    check("t3_stall_0", stall_cnt, 0);
    for (int i = 0; i < 5; i++) tick;
    check("t3_stall_5", stall_cnt, 5);
    for (int i = 0; i < 12; i++) begin
      dut_out_en = 1'b1; dut_out = i[7:0];
      tick;
      if (i == 0) check("t3_pf_release", prog_full, 0);
    end
    dut_out_en = 1'b0;
    check("t3_stall_final", stall_cnt, 6);
    check("t3_ovf", overflow, 0);
    check("t3_err", err, 0);
    check("t3_out_cnt", out_cnt, 12);

    do_reset;
    push_n(17, 8'h40);
    check("t4_ovf", overflow, 1);
    check("t4_in_cnt", in_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      dut_out_en = 1'b1; dut_out = 8'h40 + i[7:0];
      tick;
    end
    check("t4_err_cnt_0", err_cnt, 0);
    dut_out = 8'h77; tick; dut_out_en = 1'b0;
    check("t4_uf_err_cnt", err_cnt, 1);
    check("t4_uf_err", err, 1);
    check("t4_uf_idx", first_err_idx, 16);
    check("t4_uf_exp", first_err_exp, 0);
    check("t4_uf_act", first_err_act, 8'h77);
    check("t4_out_cnt", out_cnt, 17);

    do_reset;
    push_n(3, 8'h10);
    stream_end = 1'b1; tick;
    for (int i = 0; i < 99; i++) tick;
    check("t5_not_yet", done, 0);
    tick;
    check("t5_done", done, 1);
    check("t5_pass", pass, 0);
    check("t5_err", err, 1);
    check("t5_err_cnt", err_cnt, 0);

    do_reset;
    push_n(17, 8'h00);
    for (int i = 0; i < 3; i++) tick;
    check("t6_pre_ovf", overflow, 1);
    srst = 1'b0; tick; srst = 1'b1;
    check("t6_in_cnt", in_cnt, 0);
    check("t6_stall", stall_cnt, 0);
    check("t6_ovf", overflow, 0);
    check("t6_pf", prog_full, 0);
    run_stream(20, 2, -1, -1);
    check("t6_pass", pass, 1);
    check("t6_in_out", {in_cnt, out_cnt}, {32'd20, 32'd20});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
